// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter.
//   - op-select encoding for the shared adder/subtractor
//   - requester id constants carried on rsp_id and held in last_grant
//   - output register FSM state encoding
package addsub_rr_arbiter_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_rr_arbiter_rr.sv
// Two-way round-robin grant generator.
//   clk, reset : clock, asynchronous active-high reset
//   en         : grants are only issued while en is high
//   valid0/1   : request lines
//   gnt0/1     : one-hot (or zero) grant
//   gnt_any    : some requester was granted this cycle
//   gnt_id     : id of the granted requester (valid when gnt_any)
import addsub_rr_arbiter_pkg::*;

module rr_arbiter_2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_any,
    output logic gnt_id
);

    logic last_grant;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (valid0 && valid1) begin
                // Under contention, the one that did not win last time goes.
                gnt0 = (last_grant == REQ1);
                gnt1 = (last_grant == REQ0);
            end else begin
                gnt0 = valid0;
                gnt1 = valid1;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign gnt_id  = gnt1 ? REQ1 : REQ0;

    // Resetting to REQ1 makes requester 0 win the first contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ1;
        end else if (gnt_any) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/four_bit_adder_subtractor.sv
// Combinational 4-bit adder/subtractor.
//   a, b    : operands
//   sub     : OP_ADD -> a + b, OP_SUB -> a - b
//   result  : (a +/- b) mod 16
//   cout    : carry out of a + bop, where bop = b (add) or (16 - b) mod 16 (sub)
import addsub_rr_arbiter_pkg::*;

module four_bit_adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] result,
    output logic       cout
);

    logic [3:0] bop;
    logic [4:0] sum;

    // Two's complement negate instead of ~b with carry-in, so that x - 0
    // yields bop = 0 and therefore no carry out.
    assign bop    = (sub == OP_SUB) ? (4'd0 - b) : b;
    assign sum    = {1'b0, a} + {1'b0, bop};
    assign result = sum[3:0];
    assign cout   = sum[4];

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one four_bit_adder_subtractor between two valid/ready requesters
// with round-robin arbitration and a single-entry tagged result register.
//   clk, reset          : clock, asynchronous active-high reset
//   reqN_valid/ready    : per-requester handshake (ready = granted this cycle)
//   reqN_a/b/sub        : per-requester operands and op select
//   rsp_valid/ready     : result register handshake toward the consumer
//   rsp_id              : requester that produced the held result
//   rsp_result/cout     : held adder/subtractor outputs
//   grant_cnt0/1        : wrapping per-requester grant counters
import addsub_rr_arbiter_pkg::*;

module addsub_rr_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_result,
    output logic             rsp_cout,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    state_t           state_q, state_d;
    logic             can_accept;
    logic             gnt0, gnt1, gnt_any, gnt_id;
    logic [3:0]       op_a, op_b;
    logic             op_sub;
    logic [3:0]       sum_p0;
    logic             cout_p0;
    logic [3:0]       result_p1;
    logic             cout_p1;
    logic             id_p1;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // A full register can be refilled in the same cycle it drains.
    assign can_accept = (state_q == EMPTY) || (rsp_ready && (state_q == FULL));

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (can_accept),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ---- stage p0: winner operands into the shared datapath ----
    assign op_a   = gnt1 ? req1_a   : req0_a;
    assign op_b   = gnt1 ? req1_b   : req0_b;
    assign op_sub = gnt1 ? req1_sub : req0_sub;

    four_bit_adder_subtractor u_alu (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (sum_p0),
        .cout   (cout_p0)
    );

    always_comb begin
        state_d = state_q;
        if (gnt_any) begin
            state_d = FULL;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // ---- stage p1: output register, state and counters ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            result_p1 <= 4'd0;
            cout_p1   <= 1'b0;
            id_p1     <= REQ0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                result_p1 <= sum_p0;
                cout_p1   <= cout_p0;
                id_p1     <= gnt_id;
            end
            if (gnt0) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (gnt1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = id_p1;
    assign rsp_result = result_p1;
    assign rsp_cout   = cout_p1;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
module tb_addsub_rr_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_sub;
    logic [3:0]    req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_sub;
    logic [3:0]    req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [3:0]    rsp_result;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    typedef struct {
        logic       v0;
        logic [3:0] a0, b0;
        logic       s0;
        logic       v1;
        logic [3:0] a1, b1;
        logic       s1;
        logic       rr;
        logic       er0, er1;    // readies during the cycle
        logic       ev, eid;     // after the edge
        logic [3:0] eres;
        logic       ecout;
        logic [1:0] ec0, ec1;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic s0,
        input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic s1,
        input logic rr, input logic er0, input logic er1,
        input logic ev, input logic eid, input logic [3:0] eres, input logic ecout,
        input logic [1:0] ec0, input logic [1:0] ec1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
        v.rr = rr; v.er0 = er0; v.er1 = er1;
        v.ev = ev; v.eid = eid; v.eres = eres; v.ecout = ecout;
        v.ec0 = ec0; v.ec1 = ec1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic s0, input logic v1, input logic [3:0] a1,
                         input logic [3:0] b1, input logic s1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready  = rr;
    endtask

    initial begin
        //          v0 a0 b0 s0  v1 a1 b1 s1  rr  r0 r1  ev id res co c0 c1
        vecs[0]  = mk(1, 3, 5, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  8, 0, 1, 0);
        // contention: req0 7+9, req1 5-3
        vecs[1]  = mk(1, 7, 9, 0, 1, 5, 3, 1, 1, 0, 1, 1, 1,  2, 1, 1, 1);
        vecs[2]  = mk(1, 7, 9, 0, 1, 5, 3, 1, 1, 1, 0, 1, 0,  0, 1, 2, 1);
        vecs[3]  = mk(1, 7, 9, 0, 1, 5, 3, 1, 1, 0, 1, 1, 1,  2, 1, 2, 2);
        vecs[4]  = mk(1, 7, 9, 0, 1, 5, 3, 1, 1, 1, 0, 1, 0,  0, 1, 3, 2);
        // backpressure: fill with req1 3-5, then hold
        vecs[5]  = mk(0, 0, 0, 0, 1, 3, 5, 1, 1, 0, 1, 1, 1, 14, 0, 3, 3);
        vecs[6]  = mk(1, 7, 9, 0, 1, 3, 5, 1, 0, 0, 0, 1, 1, 14, 0, 3, 3);
        vecs[7]  = mk(1, 7, 9, 0, 1, 3, 5, 1, 0, 0, 0, 1, 1, 14, 0, 3, 3);
        vecs[8]  = mk(1, 7, 9, 0, 1, 3, 5, 1, 0, 0, 0, 1, 1, 14, 0, 3, 3);
        // release: drain and refill together, req0 wins, cnt0 wraps 3->0
        vecs[9]  = mk(1, 7, 9, 0, 1, 3, 5, 1, 1, 1, 0, 1, 0,  0, 1, 0, 3);
        // drain only; payload kept
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 3);
        // rsp_ready ignored while empty
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 3);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3);
        // subtract by zero, accepted from EMPTY regardless of rsp_ready
        vecs[13] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0,  9, 0, 1, 3);
        vecs[14] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  9, 0, 1, 3);
        // streaming 1+1 from req0, counter wrap
        vecs[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  2, 0, 2, 3);
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  2, 0, 3, 3);
        vecs[17] = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  2, 0, 0, 3);
        vecs[18] = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  2, 0, 1, 3);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset rsp_valid", 8'(rsp_valid), 8'd0);
        chk("reset rsp_id", 8'(rsp_id), 8'd0);
        chk("reset rsp_result", 8'(rsp_result), 8'd0);
        chk("reset rsp_cout", 8'(rsp_cout), 8'd0);
        chk("reset cnt0", 8'(grant_cnt0), 8'd0);
        chk("reset cnt1", 8'(grant_cnt1), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].s0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].rr);
            #2;
            chk($sformatf("v%0d req0_ready", i), 8'(req0_ready), 8'(vecs[i].er0));
            chk($sformatf("v%0d req1_ready", i), 8'(req1_ready), 8'(vecs[i].er1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rsp_valid", i), 8'(rsp_valid), 8'(vecs[i].ev));
            chk($sformatf("v%0d rsp_id", i), 8'(rsp_id), 8'(vecs[i].eid));
            chk($sformatf("v%0d rsp_result", i), 8'(rsp_result), 8'(vecs[i].eres));
            chk($sformatf("v%0d rsp_cout", i), 8'(rsp_cout), 8'(vecs[i].ecout));
            chk($sformatf("v%0d cnt0", i), 8'(grant_cnt0), 8'(vecs[i].ec0));
            chk($sformatf("v%0d cnt1", i), 8'(grant_cnt1), 8'(vecs[i].ec1));
        end

        // Counter wrap from a clean reset: 1, 2, 3, 0, 1
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 4'(k), 4'd2, 0, 0, 0, 0, 0, 1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d cnt0", k), 8'(grant_cnt0), 8'((k + 1) % 4));
            chk($sformatf("wrap%0d result", k), 8'(rsp_result), 8'((k + 2) % 16));
        end
        chk("wrap full", 8'(rsp_valid), 8'd1);

        // Asynchronous reset while FULL, between clock edges
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async rsp_valid", 8'(rsp_valid), 8'd0);
        chk("async cnt0", 8'(grant_cnt0), 8'd0);
        chk("async cnt1", 8'(grant_cnt1), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 2, 2, 0, 1, 1, 1, 0, 1);
        #2;
        chk("post-reset req0_ready", 8'(req0_ready), 8'd1);
        chk("post-reset req1_ready", 8'(req1_ready), 8'd0);
        @(posedge clk);
        #1;
        chk("post-reset rsp_id", 8'(rsp_id), 8'd0);
        chk("post-reset rsp_result", 8'(rsp_result), 8'd4);
        chk("post-reset cnt0", 8'(grant_cnt0), 8'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
